// File: rtl/hazard_scheduler.sv
// Hazard scheduler for the 5-stage core: operand forwarding, stall/flush sequencing,
// and a memory-wait FSM that traps into a sticky error state on memory timeout.
module hazard_scheduler #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Match_1E_M,
    input  logic       Match_1E_W,
    input  logic       Match_2E_M,
    input  logic       Match_2E_W,
    input  logic       Match_12D_E,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       PCSrcW,
    input  logic       BranchTakenE,
    input  logic       MemReqM,
    input  logic       MemAckM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MemTimeout,
    output logic [1:0] State
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        ERROR   = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;
    logic          ldr_stall, pc_pend, mem_stall, freeze;

    assign ldr_stall = Match_12D_E & MemtoRegE;
    assign pc_pend   = PCSrcD | PCSrcE | PCSrcM;
    assign mem_stall = MemReqM & ~MemAckM;
    assign freeze    = (state_q == ERROR) | mem_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_q | (state_d == ERROR);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEMWAIT;
                    cnt_d   = CW'(1);
                end
            end
            MEMWAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TMO) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ERROR:   state_d = ERROR;
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Everything is gated by rst so outputs read zero during reset, not just state.
    always_comb begin
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        MemTimeout = 1'b0;
        State      = 2'b00;
        if (rst) begin
            if (Match_1E_M & RegWriteM)      ForwardAE = 2'b10;
            else if (Match_1E_W & RegWriteW) ForwardAE = 2'b01;
            if (Match_2E_M & RegWriteM)      ForwardBE = 2'b10;
            else if (Match_2E_W & RegWriteW) ForwardBE = 2'b01;
            MemTimeout = err_q;
            State      = state_q;
            // While frozen, branch/load-use hazards are held back and re-seen after release.
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = ldr_stall | pc_pend;
                StallD = ldr_stall;
                FlushD = pc_pend | PCSrcW | BranchTakenE;
                FlushE = ldr_stall | BranchTakenE;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed-vector bench for hazard_scheduler (MEM_TIMEOUT=4), hand-computed expectations.
module tb_hazard_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic RegWriteM, RegWriteW, MemtoRegE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemAckM;
    logic [1:0] ForwardAE, ForwardBE, State;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;

    int n_vec = 0;
    int n_bad = 0;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    localparam logic [6:0] SF_NONE   = 7'b0000000;
    localparam logic [6:0] SF_FREEZE = 7'b1111001;
    localparam logic [6:0] SF_LDR    = 7'b1100010;
    localparam logic [6:0] SF_BR     = 7'b0000110;
    localparam logic [6:0] SF_PCE    = 7'b1000100;
    localparam logic [6:0] SF_PCW    = 7'b0000100;

    hazard_scheduler #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .State(State)
    );

    always #5 clk = ~clk;

    wire [6:0] sf = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = '0;
        {RegWriteM, RegWriteW, MemtoRegE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemAckM} = '0;
    endtask

    // Advance to the next falling edge, leaving inputs for the new cycle to be driven.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst = 1'b0;
        Match_1E_M = 1'b1; RegWriteM = 1'b1; MemReqM = 1'b1;
        #1;
        chk("rst_fwdA", ForwardAE, 2'b00);
        chk("rst_sf", sf, SF_NONE);
        chk("rst_state", State, 2'b00);
        chk("rst_tmo", MemTimeout, 1'b0);
        cyc(); cyc();
        chk("rst_hold_state", State, 2'b00);
        clr();
        rst = 1'b1;

        // forwarding
        cyc();
        Match_1E_M = 1'b1; RegWriteM = 1'b1; Match_1E_W = 1'b1; RegWriteW = 1'b1; #1;
        chk("fwdA_M", ForwardAE, 2'b10);
        RegWriteM = 1'b0; #1;
        chk("fwdA_W", ForwardAE, 2'b01);
        clr(); Match_2E_W = 1'b1; #1;
        chk("fwdB_noRW", ForwardBE, 2'b00);
        Match_2E_M = 1'b1; RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
        chk("fwdB_M", ForwardBE, 2'b10);
        chk("fwd_sf", sf, SF_NONE);

        // load-use
        cyc(); clr(); Match_12D_E = 1'b1; MemtoRegE = 1'b1; #1;
        chk("ldr_sf", sf, SF_LDR);
        cyc(); clr(); #1;
        chk("ldr_clear", sf, SF_NONE);

        // branch / PC writes
        cyc(); BranchTakenE = 1'b1; #1;
        chk("br_sf", sf, SF_BR);
        cyc(); clr(); PCSrcE = 1'b1; #1;
        chk("pcE_sf", sf, SF_PCE);
        cyc(); clr(); PCSrcW = 1'b1; #1;
        chk("pcW_sf", sf, SF_PCW);

        // memory wait, ack in the 4th cycle
        cyc(); clr(); MemReqM = 1'b1; #1;
        chk("mw1_sf", sf, SF_FREEZE);
        chk("mw1_state", State, 2'b00);
        cyc(); #1;
        chk("mw2_sf", sf, SF_FREEZE);
        chk("mw2_state", State, 2'b01);
        cyc(); #1;
        chk("mw3_sf", sf, SF_FREEZE);
        chk("mw3_state", State, 2'b01);
        cyc(); MemAckM = 1'b1; #1;
        chk("mw4_sf", sf, SF_NONE);
        chk("mw4_state", State, 2'b01);
        cyc(); clr(); #1;
        chk("mw_done_state", State, 2'b00);

        // memory wait with a taken branch pending
        cyc(); MemReqM = 1'b1; BranchTakenE = 1'b1; #1;
        chk("sim1_sf", sf, SF_FREEZE);
        cyc(); #1;
        chk("sim2_sf", sf, SF_FREEZE);
        cyc(); MemAckM = 1'b1; #1;
        chk("sim_ack_sf", sf, SF_BR);
        cyc(); clr(); #1;
        chk("sim_done_state", State, 2'b00);

        // timeout: ERROR entered at the edge ending the 5th stalled cycle
        cyc(); MemReqM = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("tmo_c%0d_state", i), State, (i == 1) ? 2'b00 : 2'b01);
            chk($sformatf("tmo_c%0d_flag", i), MemTimeout, 1'b0);
            cyc();
        end
        #1;
        chk("tmo_state", State, 2'b10);
        chk("tmo_flag", MemTimeout, 1'b1);
        chk("tmo_sf", sf, SF_FREEZE);
        MemAckM = 1'b1; Match_2E_W = 1'b1; RegWriteW = 1'b1;
        cyc(); cyc(); #1;
        chk("err_sticky_state", State, 2'b10);
        chk("err_sticky_flag", MemTimeout, 1'b1);
        chk("err_sf", sf, SF_FREEZE);
        chk("err_fwdB", ForwardBE, 2'b01);
        clr(); #1;
        chk("err_idle_sf", sf, SF_FREEZE);

        // asynchronous reset mid-cycle
        #1 rst = 1'b0; #1;
        chk("arst_state", State, 2'b00);
        chk("arst_flag", MemTimeout, 1'b0);
        chk("arst_sf", sf, SF_NONE);
        cyc(); rst = 1'b1; #1;
        chk("post_rst_state", State, 2'b00);
        chk("post_rst_flag", MemTimeout, 1'b0);
        cyc(); #1;
        chk("post_rst_run", State, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
